// File: rtl/jtlb_search.sv
// jtlb_search: joint instruction-side TLB with ENTRIES even/odd 4 KB page pairs.
// A request is resolved in the accepting step for address-error and unmapped
// addresses. Any other request is searched sequentially, one entry per step,
// and the lowest matching index wins.
//
// Optional feature macro: JTLB_PROBE_EN adds a probe request that reports the
// index of the first matching entry, ignoring valid bits.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   phi2                  step enable; no state changes without it
//   req, va, asid         translation request, sampled at an idle step
//   busy                  search in progress
//   done                  one-step result pulse
//   pa, miss, ade,
//   inval, cache          result, held until the next accept
//   we, windex, wvpn2,
//   wasid, wg, wpfn0/1,
//   wc0/1, wv0/1          entry write port
//   probe, probeidx,
//   probemiss             probe request and result (JTLB_PROBE_EN only)
module jtlb_search #(
  parameter int unsigned ENTRIES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phi2,
  input  logic        req,
  input  logic [63:0] va,
  input  logic [7:0]  asid,
`ifdef JTLB_PROBE_EN
  input  logic        probe,
  output logic [4:0]  probeidx,
  output logic        probemiss,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] pa,
  output logic        miss,
  output logic        ade,
  output logic        inval,
  output logic        cache,
  input  logic        we,
  input  logic [4:0]  windex,
  input  logic [18:0] wvpn2,
  input  logic [7:0]  wasid,
  input  logic        wg,
  input  logic [19:0] wpfn0,
  input  logic [19:0] wpfn1,
  input  logic [2:0]  wc0,
  input  logic [2:0]  wc1,
  input  logic        wv0,
  input  logic        wv1
);

  localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  // Entry table
  logic [ENTRIES-1:0] present_q;
  logic [18:0]        e_vpn2_q [ENTRIES];
  logic [7:0]         e_asid_q [ENTRIES];
  logic               e_g_q    [ENTRIES];
  logic [19:0]        e_pfn0_q [ENTRIES];
  logic [19:0]        e_pfn1_q [ENTRIES];
  logic [2:0]         e_c0_q   [ENTRIES];
  logic [2:0]         e_c1_q   [ENTRIES];
  logic               e_v0_q   [ENTRIES];
  logic               e_v1_q   [ENTRIES];

  // Search state and registered outputs
  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] va_q, va_d;
  logic [7:0]  asid_q, asid_d;
  logic        done_q, done_d;
  logic [31:0] pa_q, pa_d;
  logic        miss_q, miss_d;
  logic        ade_q, ade_d;
  logic        inval_q, inval_d;
  logic        cache_q, cache_d;
`ifdef JTLB_PROBE_EN
  logic        probe_q, probe_d;
  logic [4:0]  probeidx_q, probeidx_d;
  logic        probemiss_q, probemiss_d;
`endif

  logic [IW-1:0] widx;
  logic [IW-1:0] sel;
  logic          hit;
  logic [19:0]   sel_pfn;
  logic [2:0]    sel_c;
  logic          sel_v;

  assign widx = windex[IW-1:0];
  assign sel  = idx_q[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      present_q <= '0;
    end else if (phi2 && we) begin
      present_q[widx] <= 1'b1;
    end
  end

  // Entry payload needs no reset: it is never looked at while present is clear.
  always_ff @(posedge clk) begin
    if (phi2 && we) begin
      e_vpn2_q[widx] <= wvpn2;
      e_asid_q[widx] <= wasid;
      e_g_q[widx]    <= wg;
      e_pfn0_q[widx] <= wpfn0;
      e_pfn1_q[widx] <= wpfn1;
      e_c0_q[widx]   <= wc0;
      e_c1_q[widx]   <= wc1;
      e_v0_q[widx]   <= wv0;
      e_v1_q[widx]   <= wv1;
    end
  end

  // Compare the single entry under the search index against the latched request.
  always_comb begin
    hit     = present_q[sel] && (e_vpn2_q[sel] == va_q[31:13]) &&
              (e_g_q[sel] || (e_asid_q[sel] == asid_q));
    sel_pfn = va_q[12] ? e_pfn1_q[sel] : e_pfn0_q[sel];
    sel_c   = va_q[12] ? e_c1_q[sel]   : e_c0_q[sel];
    sel_v   = va_q[12] ? e_v1_q[sel]   : e_v0_q[sel];
  end

  // Next-state, evaluated as if this clock edge were a step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    va_d    = va_q;
    asid_d  = asid_q;
    done_d  = 1'b0;
    pa_d    = pa_q;
    miss_d  = miss_q;
    ade_d   = ade_q;
    inval_d = inval_q;
    cache_d = cache_q;
`ifdef JTLB_PROBE_EN
    probe_d     = probe_q;
    probeidx_d  = probeidx_q;
    probemiss_d = probemiss_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req) begin
          va_d    = va[31:0];
          asid_d  = asid;
          pa_d    = '0;
          miss_d  = 1'b0;
          ade_d   = 1'b0;
          inval_d = 1'b0;
          cache_d = 1'b0;
`ifdef JTLB_PROBE_EN
          probe_d     = 1'b0;
          probeidx_d  = '0;
          probemiss_d = 1'b0;
`endif
          if (va[63:32] != {32{va[31]}}) begin
            ade_d  = 1'b1;
            done_d = 1'b1;
          end else if (va[31:30] == 2'b10) begin
            pa_d    = {3'b000, va[28:0]};
            cache_d = ~va[29];
            done_d  = 1'b1;
          end else begin
            state_d = StSearch;
            idx_d   = '0;
          end
`ifdef JTLB_PROBE_EN
        end else if (probe) begin
          va_d        = va[31:0];
          asid_d      = asid;
          pa_d        = '0;
          miss_d      = 1'b0;
          ade_d       = 1'b0;
          inval_d     = 1'b0;
          cache_d     = 1'b0;
          probe_d     = 1'b1;
          probeidx_d  = '0;
          probemiss_d = 1'b0;
          state_d     = StSearch;
          idx_d       = '0;
`endif
        end
      end

      StSearch: begin
        if (we) begin
          // Restart so the result always reflects the table after the write.
          idx_d = '0;
`ifdef JTLB_PROBE_EN
        end else if (probe_q && hit) begin
          probeidx_d = idx_q;
          done_d     = 1'b1;
          state_d    = StIdle;
`endif
        end else if (hit) begin
          if (sel_v) begin
            pa_d    = {sel_pfn, va_q[11:0]};
            cache_d = (sel_c != 3'b010);
          end else begin
            inval_d = 1'b1;
            pa_d    = '0;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (idx_q == 5'(ENTRIES - 1)) begin
`ifdef JTLB_PROBE_EN
          if (probe_q) begin
            probemiss_d = 1'b1;
          end else begin
            miss_d = 1'b1;
            pa_d   = '0;
          end
`else
          miss_d = 1'b1;
          pa_d   = '0;
`endif
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      va_q    <= '0;
      asid_q  <= '0;
      done_q  <= 1'b0;
      pa_q    <= '0;
      miss_q  <= 1'b0;
      ade_q   <= 1'b0;
      inval_q <= 1'b0;
      cache_q <= 1'b0;
`ifdef JTLB_PROBE_EN
      probe_q     <= 1'b0;
      probeidx_q  <= '0;
      probemiss_q <= 1'b0;
`endif
    end else if (phi2) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      va_q    <= va_d;
      asid_q  <= asid_d;
      done_q  <= done_d;
      pa_q    <= pa_d;
      miss_q  <= miss_d;
      ade_q   <= ade_d;
      inval_q <= inval_d;
      cache_q <= cache_d;
`ifdef JTLB_PROBE_EN
      probe_q     <= probe_d;
      probeidx_q  <= probeidx_d;
      probemiss_q <= probemiss_d;
`endif
    end
  end

  assign busy  = (state_q == StSearch);
  assign done  = done_q;
  assign pa    = pa_q;
  assign miss  = miss_q;
  assign ade   = ade_q;
  assign inval = inval_q;
  assign cache = cache_q;
`ifdef JTLB_PROBE_EN
  assign probeidx  = probeidx_q;
  assign probemiss = probemiss_q;
`endif

endmodule
